reg_file_fwd: RTL

- 32-entry general-purpose register file for the ID stage. It answers the two read requests and the one write request that the ID-stage register-address decode emits.
- Provides two combinational read ports and one synchronous write port (WB stage).
- Forwards in-flight EX/MEM results with fixed priority and raises a load-use stall request toward the pipeline controller.

---
 rtl/reg_file_fwd_pkg.sv | 25 ++
 rtl/reg_bypass_sel.sv | 34 +++
 rtl/reg_file_fwd.sv | 104 ++++++++++
 3 files changed

// File: rtl/reg_file_fwd_pkg.sv
// Shared widths, register-address constants and the stage write-port payload for reg_file_fwd.
package reg_file_fwd_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned REG_COUNT  = 32;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t REG_ZERO = addr_t'(0);
    localparam addr_t REG_RA   = addr_t'(31);

    // One pipeline stage's pending register write.
    typedef struct packed {
        logic  en;
        addr_t addr;
        data_t data;
    } wr_port_t;

    function automatic logic wr_hits(input wr_port_t p, input addr_t a);
        return p.en && (p.addr == a);
    endfunction

endpackage

// File: rtl/reg_bypass_sel.sv
// Per-read-port forwarding mux: EX > MEM > WB > array; $0 and disabled reads return zero.
module reg_bypass_sel
    import reg_file_fwd_pkg::*;
(
    input  logic     i_en,
    input  addr_t    i_addr,
    input  wr_port_t i_ex,
    input  logic     i_ex_load,
    input  wr_port_t i_mem,
    input  wr_port_t i_wb,
    input  data_t    i_arr_data,
    output data_t    o_data,
    output logic     o_ex_load_hit
);

    always_comb begin
        o_data        = '0;
        o_ex_load_hit = 1'b0;
        if (i_en && (i_addr != REG_ZERO)) begin
            if (wr_hits(i_ex, i_addr)) begin
                o_data = i_ex.data;
            end else if (wr_hits(i_mem, i_addr)) begin
                o_data = i_mem.data;
            end else if (wr_hits(i_wb, i_addr)) begin
                o_data = i_wb.data;
            end else begin
                o_data = i_arr_data;
            end
            // A load in EX has no data yet; the consumer must wait one cycle.
            o_ex_load_hit = i_ex_load && wr_hits(i_ex, i_addr);
        end
    end

endmodule

// File: rtl/reg_file_fwd.sv
// ID-stage register file: 2 combinational forwarded read ports, 1 WB write port, load-use stall.
// Optional REGFILE_DEBUG_EN adds a raw debug read port and an accepted-write counter.
module reg_file_fwd
    import reg_file_fwd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic                  read_en_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic                  ex_write_en,
    input  logic [ADDR_WIDTH-1:0] ex_write_addr,
    input  logic [DATA_WIDTH-1:0] ex_write_data,
    input  logic                  ex_load_flag,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_write_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  stall_request
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic [31:0]           debug_write_count
`endif
);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

    wr_port_t w_ex;
    wr_port_t w_mem;
    wr_port_t w_wb;
    data_t    w_sel_1;
    data_t    w_sel_2;
    logic     w_hit_1;
    logic     w_hit_2;
    logic     w_wb_accept;

    assign w_ex        = '{en: ex_write_en,  addr: ex_write_addr,  data: ex_write_data};
    assign w_mem       = '{en: mem_write_en, addr: mem_write_addr, data: mem_write_data};
    assign w_wb        = '{en: write_en,     addr: write_addr,     data: write_data};
    assign w_wb_accept = write_en && (write_addr != REG_ZERO);

    // Entry 0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_accept) begin
            r_regs[write_addr] <= write_data;
        end
    end

    reg_bypass_sel u_sel_1 (
        .i_en          (read_en_1),
        .i_addr        (read_addr_1),
        .i_ex          (w_ex),
        .i_ex_load     (ex_load_flag),
        .i_mem         (w_mem),
        .i_wb          (w_wb),
        .i_arr_data    (r_regs[read_addr_1]),
        .o_data        (w_sel_1),
        .o_ex_load_hit (w_hit_1)
    );

    reg_bypass_sel u_sel_2 (
        .i_en          (read_en_2),
        .i_addr        (read_addr_2),
        .i_ex          (w_ex),
        .i_ex_load     (ex_load_flag),
        .i_mem         (w_mem),
        .i_wb          (w_wb),
        .i_arr_data    (r_regs[read_addr_2]),
        .o_data        (w_sel_2),
        .o_ex_load_hit (w_hit_2)
    );

    assign read_data_1   = rst ? '0 : w_sel_1;
    assign read_data_2   = rst ? '0 : w_sel_2;
    assign stall_request = !rst && (w_hit_1 || w_hit_2);

`ifdef REGFILE_DEBUG_EN
    logic [31:0] r_write_count;

    // Counts writes that actually land in the array; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_count <= '0;
        end else if (w_wb_accept) begin
            r_write_count <= r_write_count + 32'(1);
        end
    end

    assign debug_data        = rst ? '0 : r_regs[debug_addr];
    assign debug_write_count = r_write_count;
`endif

endmodule
